grid_slide_engine: RTL

//  Parametrised N x N slide/merge engine for the 2048 game datapath: on start, slides the whole board in one

---
 rtl/grid_pkg.sv | 28 ++
 rtl/line_merge.sv | 77 +++++++
 rtl/grid_slide_engine.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/grid_pkg.sv
// Shared encodings for the 2048 slide/merge engine.
// Direction and FSM state types plus the board cell offset helper.
package grid_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LINE = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int cell_off(
    input int r,
    input int c,
    input int n,
    input int cw
  );
    return (r * n + c) * cw;
  endfunction

endpackage

// File: rtl/line_merge.sv
// Combinational 2048 line slide: compact toward element 0,
// merge first equal pairs once, report score and change.
module line_merge #(
  parameter int N  = 4,
  parameter int CW = 4,
  parameter int SW = 32
) (
  input  logic [N*CW-1:0] line_in,
  output logic [N*CW-1:0] line_out,
  output logic [SW-1:0]   line_score,
  output logic            line_changed
);

  localparam logic [CW-1:0] EMAX = '1;

  function automatic logic [SW-1:0] sat_add(
    input logic [SW-1:0] a,
    input logic [SW-1:0] b
  );
    logic [SW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SW] ? '1 : s[SW-1:0];
  endfunction

  function automatic logic [SW-1:0] pow2(
    input logic [CW:0] e
  );
    logic [SW-1:0] one;
    one = {{(SW-1){1'b0}}, 1'b1};
    if (int'(e) >= SW) return '1;
    return one << e;
  endfunction

  // comp[N] stays zero so the pair look-ahead never leaves the array
  logic [CW-1:0] comp [N+1];
  logic [CW-1:0] res  [N+1];
  int            k;
  int            o;
  logic          skip;

  always_comb begin
    k          = 0;
    o          = 0;
    skip       = 1'b0;
    line_score = '0;
    line_out   = '0;
    for (int i = 0; i <= N; i++) begin
      comp[i] = '0;
      res[i]  = '0;
    end
    for (int i = 0; i < N; i++) begin
      if (line_in[i*CW +: CW] != '0) begin
        comp[k] = line_in[i*CW +: CW];
        k++;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[i] != '0) begin
        if (comp[i] == comp[i+1] && comp[i] != EMAX) begin
          res[o]     = comp[i] + 1'b1;
          line_score = sat_add(line_score,
                         pow2({1'b0, comp[i]} + 1'b1));
          skip       = 1'b1;
        end else begin
          res[o] = comp[i];
        end
        o++;
      end
    end
    for (int i = 0; i < N; i++)
      line_out[i*CW +: CW] = res[i];
    line_changed = (line_out != line_in);
  end

endmodule

// File: rtl/grid_slide_engine.sv
// N x N 2048 board engine: slides one line per cycle,
// accumulates merge score, then evaluates win/lose.
module grid_slide_engine
  import grid_pkg::*;
#(
  parameter int N       = 4,
  parameter int CW      = 4,
  parameter int WIN_EXP = 11,
  parameter int SW      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [N*N*CW-1:0] board_in,
  input  logic              start,
  input  logic [1:0]        dir,
  output logic              busy,
  output logic              done,
  output logic              moved,
  output logic [SW-1:0]     score_delta,
  output logic              win,
  output logic              lose,
  output logic [N*N*CW-1:0] board_out
);

  localparam int BW = N * N * CW;
  localparam int IW = $clog2(N);
  localparam logic [CW-1:0] WIN_C = CW'(WIN_EXP);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);

  function automatic logic [SW-1:0] sat_add(
    input logic [SW-1:0] a,
    input logic [SW-1:0] b
  );
    logic [SW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SW] ? '1 : s[SW-1:0];
  endfunction

  state_e        state_q;
  dir_e          dir_q;
  logic [IW-1:0] idx_q;
  logic [BW-1:0] board_q;
  logic          busy_q;
  logic          done_q;
  logic          moved_q;
  logic [SW-1:0] score_q;
  logic          win_q;
  logic          lose_q;

  int            off [N];
  logic [N*CW-1:0] line_in;
  logic [N*CW-1:0] line_out;
  logic [SW-1:0]   line_score;
  logic            line_chg;

  // element 0 of the line is the cell nearest the slide edge
  always_comb begin
    line_in = '0;
    for (int i = 0; i < N; i++) begin
      off[i] = 0;
      unique case (1'b1)
        dir_q == DIR_UP:
          off[i] = cell_off(i, int'(idx_q), N, CW);
        dir_q == DIR_DOWN:
          off[i] = cell_off(N-1-i, int'(idx_q), N, CW);
        dir_q == DIR_LEFT:
          off[i] = cell_off(int'(idx_q), i, N, CW);
        default:
          off[i] = cell_off(int'(idx_q), N-1-i, N, CW);
      endcase
      line_in[i*CW +: CW] = board_q[off[i] +: CW];
    end
  end

  line_merge #(
    .N  (N),
    .CW (CW),
    .SW (SW)
  ) u_line_merge (
    .line_in      (line_in),
    .line_out     (line_out),
    .line_score   (line_score),
    .line_changed (line_chg)
  );

  logic win_c;
  logic has_empty;
  logic has_pair;

  always_comb begin
    win_c     = 1'b0;
    has_empty = 1'b0;
    has_pair  = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (board_q[cell_off(r, c, N, CW) +: CW] >= WIN_C)
          win_c = 1'b1;
        if (board_q[cell_off(r, c, N, CW) +: CW] == '0)
          has_empty = 1'b1;
      end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N-1; c++)
        if (board_q[cell_off(r, c, N, CW) +: CW] ==
            board_q[cell_off(r, c+1, N, CW) +: CW])
          has_pair = 1'b1;
    for (int r = 0; r < N-1; r++)
      for (int c = 0; c < N; c++)
        if (board_q[cell_off(r, c, N, CW) +: CW] ==
            board_q[cell_off(r+1, c, N, CW) +: CW])
          has_pair = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      idx_q   <= '0;
      board_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      moved_q <= 1'b0;
      score_q <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (load) begin
            board_q <= board_in;
          end else if (start) begin
            dir_q   <= dir_e'(dir);
            idx_q   <= '0;
            moved_q <= 1'b0;
            score_q <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_LINE;
          end
        end
        ST_LINE: begin
          for (int i = 0; i < N; i++)
            board_q[off[i] +: CW] <= line_out[i*CW +: CW];
          moved_q <= moved_q | line_chg;
          score_q <= sat_add(score_q, line_score);
          if (idx_q == LAST)
            state_q <= ST_EVAL;
          else
            idx_q <= idx_q + 1'b1;
        end
        ST_EVAL: begin
          win_q   <= win_c;
          lose_q  <= ~has_empty & ~has_pair;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign moved       = moved_q;
  assign score_delta = score_q;
  assign win         = win_q;
  assign lose        = lose_q;
  assign board_out   = board_q;

endmodule
